// File: rtl/z_pack_pkg.sv
// Shared types for the z-bit frame packer: frame record, count width and packer state.
package z_pack_pkg;

  localparam int unsigned FRAME_W = 8;
  localparam int unsigned LW      = $clog2(FRAME_W + 1);

  typedef struct packed {
    logic [FRAME_W-1:0] data;
    logic [LW-1:0]      len;
    logic [LW-1:0]      ones;
  } frame_t;

  typedef enum logic {
    COLLECT = 1'b0,
    PARTIAL = 1'b1
  } pack_state_e;

endpackage

// File: rtl/z_frame_fifo.sv
// Synchronous FIFO of frame_t records. Full-FIFO push is accepted only alongside a pop.
module z_frame_fifo
  import z_pack_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LVW  = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push_i,
  input  frame_t         wr_frame_i,
  input  logic           pop_i,
  output frame_t         rd_frame_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [LVW-1:0] level_o
);

  frame_t         mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVW-1:0] level_q, level_d;
  logic           do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVW'(DEPTH));
  assign level_o = level_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is masked while empty so the stream outputs read zero after reset.
  assign rd_frame_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVW'(1);
      2'b01:   level_d = level_q - LVW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  // NOTE: storage is not reset; pointers and level define validity, and reset-free RAM maps to memory cells.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_frame_i;
  end

endmodule

// File: rtl/z_frame_packer.sv
// Packs qualified serial z bits LSB-first into frames, buffers them and streams them out
// with valid/ready, counting frames dropped on overflow. WIDTH must equal FRAME_W.
module z_frame_packer
  import z_pack_pkg::*;
#(
  parameter int unsigned WIDTH = FRAME_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16,
  localparam int unsigned LVW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z_valid,
  input  logic             z,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [LW-1:0]    m_len,
  output logic [LW-1:0]    m_ones,
  output logic [LVW-1:0]   level,
  output logic             overflow,
  output logic [CNTW-1:0]  drop_count
);

  pack_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_next;
  logic [LW-1:0]    bit_cnt_q, bit_cnt_d, cnt_next;
  logic [LW-1:0]    ones_cnt_q, ones_cnt_d, ones_next;
  logic             overflow_q;
  logic [CNTW-1:0]  drop_cnt_q;

  logic             full_close, flush_close, close;
  logic             pop, push, drop, push_ok;
  logic             fifo_full, fifo_empty;
  frame_t           push_frame, head_frame;

  // Same-cycle z bit is folded in before any close so a flush can carry it.
  assign acc_next  = acc_q | (WIDTH'(z_valid & z) << bit_cnt_q);
  assign cnt_next  = bit_cnt_q + LW'(z_valid);
  assign ones_next = ones_cnt_q + LW'(z_valid & z);

  assign full_close  = z_valid && (bit_cnt_q == LW'(WIDTH - 1));
  assign flush_close = flush && ((state_q == PARTIAL) || z_valid);
  assign close       = full_close || flush_close;

  assign push_frame = '{data: acc_next, len: cnt_next, ones: ones_next};

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign push_ok = ~fifo_full | pop;
  assign push    = close & push_ok;
  assign drop    = close & ~push_ok;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    if (close) begin
      state_d    = COLLECT;
      acc_d      = '0;
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
    end else if (z_valid) begin
      state_d    = PARTIAL;
      acc_d      = acc_next;
      bit_cnt_d  = cnt_next;
      ones_cnt_d = ones_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNTW'(1);
      end
    end
  end

  z_frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .wr_frame_i (push_frame),
    .pop_i      (pop),
    .rd_frame_o (head_frame),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (level)
  );

  assign m_data     = head_frame.data;
  assign m_len      = head_frame.len;
  assign m_ones     = head_frame.ones;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_z_frame_packer.sv
// Directed bench for z_frame_packer: a vector table for framing/flush, hand sequences for
// back-pressure, overflow, saturation and reset.
module tb_z_frame_packer;
  import z_pack_pkg::*;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int CW  = 2;
  localparam int LWT = $clog2(W + 1);
  localparam int LVT = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           reset, z_valid, z, flush, m_ready;
  logic           m_valid, overflow;
  logic [W-1:0]   m_data;
  logic [LWT-1:0] m_len, m_ones;
  logic [LVT-1:0] level;
  logic [CW-1:0]  drop_count;

  int total = 0;
  int bad   = 0;

  z_frame_packer #(.WIDTH(W), .DEPTH(D), .CNTW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .z_valid    (z_valid),
    .z          (z),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_len      (m_len),
    .m_ones     (m_ones),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           zv, zb, fl, rdy;
    logic           ev;
    logic [W-1:0]   ed;
    logic [LWT-1:0] el, eo;
    logic [LVT-1:0] elv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic zv, input logic zb, input logic fl, input logic rdy,
                              input logic ev, input logic [W-1:0] ed, input int el, input int eo,
                              input int elv);
    vec_t v;
    v.zv = zv; v.zb = zb; v.fl = fl; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = LWT'(el); v.eo = LWT'(eo); v.elv = LVT'(elv);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams n bits of data LSB-first; m_ready is rdy_body except on the last bit.
  task automatic send_bits(input logic [W-1:0] data, input int n, input logic rdy_body,
                           input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      z_valid = 1'b1;
      z       = data[i];
      m_ready = (i == n - 1) ? rdy_last : rdy_body;
      step();
    end
    z_valid = 1'b0;
    z       = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic drain(input logic [W-1:0] exp_q[$], input string tag);
    m_ready = 1'b1;
    foreach (exp_q[i]) begin
      check({tag, "_valid"}, m_valid, 1'b1);
      check({tag, "_data"}, m_data, exp_q[i]);
      check({tag, "_len"}, m_len, W);
      check({tag, "_ones"}, m_ones, $countones(exp_q[i]));
      step();
    end
    m_ready = 1'b0;
    check({tag, "_empty_valid"}, m_valid, 1'b0);
    check({tag, "_empty_level"}, level, 0);
  endtask

  initial begin
    vec_t v;
    logic [W-1:0] q[$];

    reset = 1'b1; z_valid = 1'b0; z = 1'b0; flush = 1'b0; m_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 0);
    check("rst_len", m_len, 0);
    check("rst_ones", m_ones, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drops", drop_count, 0);

    // Full frame 1,0,1,1,0,0,1,0 -> 0x4D.
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 8'h4D, 8, 4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Partial 1,1,0 closed by a lone flush, then lone flushes are no-ops.
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 8'h03, 3, 2, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    // Flush with the 5th bit (z=1): 1,0,0,1,1 -> 0x19; next bit starts at position 0.
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 8'h19, 5, 3, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 8'h01, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    // One-bit frame from z_valid+flush in COLLECT, z=0.
    vecs.push_back(mk(1, 0, 1, 1, 1, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      z_valid = v.zv; z = v.zb; flush = v.fl; m_ready = v.rdy;
      step();
      check($sformatf("vec%0d_valid", i), m_valid, v.ev);
      if (v.ev) begin
        check($sformatf("vec%0d_data", i), m_data, v.ed);
        check($sformatf("vec%0d_len", i), m_len, v.el);
        check($sformatf("vec%0d_ones", i), m_ones, v.eo);
      end
      check($sformatf("vec%0d_level", i), level, v.elv);
    end
    z_valid = 1'b0; z = 1'b0; flush = 1'b0; m_ready = 1'b0;

    // Overflow: five frames into four entries with no consumer.
    send_bits(8'hA1, W, 1'b0, 1'b0);
    send_bits(8'hB2, W, 1'b0, 1'b0);
    send_bits(8'hC3, W, 1'b0, 1'b0);
    send_bits(8'hD4, W, 1'b0, 1'b0);
    check("fill_level", level, 4);
    check("fill_overflow", overflow, 1'b0);
    check("fill_head_hold", m_data, 8'hA1);
    send_bits(8'hE5, W, 1'b0, 1'b0);
    check("ovf_level", level, 4);
    check("ovf_overflow", overflow, 1'b1);
    check("ovf_drops", drop_count, 1);
    q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    drain(q, "ovf_drain");

    // Full FIFO, close coincides with a pop: no drop.
    send_bits(8'h01, W, 1'b0, 1'b0);
    send_bits(8'h02, W, 1'b0, 1'b0);
    send_bits(8'h03, W, 1'b0, 1'b0);
    send_bits(8'h04, W, 1'b0, 1'b0);
    send_bits(8'h85, W, 1'b0, 1'b1);
    check("swap_level", level, 4);
    check("swap_drops", drop_count, 1);
    check("swap_head", m_data, 8'h02);
    q = '{8'h02, 8'h03, 8'h04, 8'h85};
    drain(q, "swap_drain");

    // Drop counter saturates at all-ones (CNTW=2 -> 3).
    for (int i = 0; i < 8; i++) send_bits(W'(8'h10 + i), W, 1'b0, 1'b0);
    check("sat_drops", drop_count, 3);
    check("sat_overflow", overflow, 1'b1);
    q = '{8'h10, 8'h11, 8'h12, 8'h13};
    drain(q, "sat_drain");

    // Reset mid-frame with two frames buffered.
    send_bits(8'h21, W, 1'b0, 1'b0);
    send_bits(8'h22, W, 1'b0, 1'b0);
    send_bits(8'h07, 3, 1'b0, 1'b0);
    check("pre_rst_level", level, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", m_valid, 1'b0);
    check("mid_rst_level", level, 0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_drops", drop_count, 0);
    send_bits(8'h5A, W, 1'b0, 1'b0);
    check("post_rst_valid", m_valid, 1'b1);
    check("post_rst_data", m_data, 8'h5A);
    check("post_rst_len", m_len, W);
    check("post_rst_ones", m_ones, 4);
    check("post_rst_level", level, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
